// File: rtl/exibe_sequencia_pkg.sv
// Shared game definitions: playback FSM state codes, one-hot button codes, RGB colours.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package exibe_sequencia_pkg;

    // Playback FSM state codes
    localparam logic [2:0] EST_OCIOSO  = 3'd0;
    localparam logic [2:0] EST_CARREGA = 3'd1;
    localparam logic [2:0] EST_ACENDE  = 3'd2;
    localparam logic [2:0] EST_APAGA   = 3'd3;
    localparam logic [2:0] EST_PROXIMO = 3'd4;
    localparam logic [2:0] EST_FIM     = 3'd5;

    typedef enum logic [2:0] {
        OCIOSO  = EST_OCIOSO,
        CARREGA = EST_CARREGA,
        ACENDE  = EST_ACENDE,
        APAGA   = EST_APAGA,
        PROXIMO = EST_PROXIMO,
        FIM     = EST_FIM
    } estado_t;

    // One-hot button codes as stored in the game memory
    localparam logic [3:0] BOTAO_VERMELHO = 4'b0001;
    localparam logic [3:0] BOTAO_VERDE    = 4'b0010;
    localparam logic [3:0] BOTAO_AZUL     = 4'b0100;
    localparam logic [3:0] BOTAO_AMARELO  = 4'b1000;

    // RGB colours, also used by the datapath colour conversion
    localparam logic [2:0] COR_VERMELHO = 3'b100;
    localparam logic [2:0] COR_VERDE    = 3'b010;
    localparam logic [2:0] COR_AZUL     = 3'b001;
    localparam logic [2:0] COR_AMARELO  = 3'b110;
    localparam logic [2:0] COR_APAGADA  = 3'b000;

    // Button code to RGB colour; anything that is not a valid button is dark
    function automatic logic [2:0] cor_de_botao(input logic [3:0] botao);
        logic [2:0] cor;
        case (botao)
            BOTAO_VERMELHO: cor = COR_VERMELHO;
            BOTAO_VERDE:    cor = COR_VERDE;
            BOTAO_AZUL:     cor = COR_AZUL;
            BOTAO_AMARELO:  cor = COR_AMARELO;
            default:        cor = COR_APAGADA;
        endcase
        return cor;
    endfunction

    // True when the code is exactly one of the four buttons
    function automatic logic eh_botao_valido(input logic [3:0] botao);
        return (botao == BOTAO_VERMELHO) || (botao == BOTAO_VERDE) ||
               (botao == BOTAO_AZUL)     || (botao == BOTAO_AMARELO);
    endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// Phase timer for playback: counts cycles of the lit or dark phase and flags the last one.
// Latency: fim is combinational from the count; it is high during the final cycle of a phase.
// Backpressure: none; the FSM clears it on every phase change and enables it while timing.
module temporizador_exibicao #(
    parameter int NT               = 11,
    parameter int CONTAGEM_ACESO   = 2000,
    parameter int CONTAGEM_APAGADO = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic habilita,
    input  logic fase_apagada,
    output logic fim
);

    // Terminal values: a phase of N cycles ends when the count reaches N-1
    localparam logic [NT-1:0] ULTIMO_ACESO   = NT'(CONTAGEM_ACESO - 1);
    localparam logic [NT-1:0] ULTIMO_APAGADO = NT'(CONTAGEM_APAGADO - 1);

    logic [NT-1:0] contagem;

    // Cycle counter: clear has priority over counting
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (habilita) begin
            contagem <= contagem + NT'(1);
        end
    end

    assign fim = habilita &&
                 (contagem == (fase_apagada ? ULTIMO_APAGADO : ULTIMO_ACESO));

endmodule

// File: rtl/exibe_sequencia.sv
// Memory-game playback: shows mem[0..limite] on leds/rgb, each lit T_ACESO then dark T_APAGADO.
// Latency: first entry lit 2 cycles after iniciar; pronto after (limite+1)*(T_ACESO+T_APAGADO+2)+1.
// Backpressure: iniciar is ignored while busy; abortar drops to idle from any state, no pronto.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int T_ACESO   = 2000,
    parameter int T_APAGADO = 1000,
    parameter int NT        = 11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic [2:0] rgb,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro_codigo
);

    estado_t    estado;
    logic [3:0] limite_capturado;

    logic tmr_limpa;
    logic tmr_habilita;
    logic tmr_fase_apagada;
    logic tmr_fim;

    // The timer only runs in the two timed phases and restarts when the lit phase hands over to dark
    assign tmr_habilita     = (estado == ACENDE) || (estado == APAGA);
    assign tmr_fase_apagada = (estado == APAGA);
    assign tmr_limpa        = !tmr_habilita || ((estado == ACENDE) && tmr_fim);

    temporizador_exibicao #(
        .NT               (NT),
        .CONTAGEM_ACESO   (T_ACESO),
        .CONTAGEM_APAGADO (T_APAGADO)
    ) u_temporizador (
        .clock        (clock),
        .reset        (reset),
        .limpa        (tmr_limpa),
        .habilita     (tmr_habilita),
        .fase_apagada (tmr_fase_apagada),
        .fim          (tmr_fim)
    );

    // Playback FSM; outputs are loaded on the transition edges so they line up with the states
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado           <= OCIOSO;
            limite_capturado <= 4'd0;
            endereco         <= 4'd0;
            leds             <= 4'd0;
            rgb              <= COR_APAGADA;
            ocupado          <= 1'b0;
            pronto           <= 1'b0;
            erro_codigo      <= 1'b0;
        end else if (abortar) begin
            // Abort beats everything, including a simultaneous start; the address is kept
            estado  <= OCIOSO;
            leds    <= 4'd0;
            rgb     <= COR_APAGADA;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        limite_capturado <= limite;
                        endereco         <= 4'd0;
                        erro_codigo      <= 1'b0;
                        ocupado          <= 1'b1;
                        estado           <= CARREGA;
                    end
                end
                CARREGA: begin
                    // dado for the current address is valid now; latch it for the whole lit phase
                    leds <= dado;
                    rgb  <= cor_de_botao(dado);
                    if (!eh_botao_valido(dado)) begin
                        erro_codigo <= 1'b1;
                    end
                    estado <= ACENDE;
                end
                ACENDE: begin
                    if (tmr_fim) begin
                        leds   <= 4'd0;
                        rgb    <= COR_APAGADA;
                        estado <= APAGA;
                    end
                end
                APAGA: begin
                    if (tmr_fim) begin
                        estado <= PROXIMO;
                    end
                end
                PROXIMO: begin
                    // Compare before incrementing so limite=15 never wraps the address
                    if (endereco == limite_capturado) begin
                        pronto <= 1'b1;
                        estado <= FIM;
                    end else begin
                        endereco <= endereco + 4'd1;
                        estado   <= CARREGA;
                    end
                end
                FIM: begin
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule
